// File: rtl/elevator_pkg.sv
// Shared encodings and FSM state type for the elevator controller.
package elevator_pkg;

  // Motor command encodings
  localparam logic [1:0] ENG_STOP = 2'b00;
  localparam logic [1:0] ENG_UP   = 2'b01;
  localparam logic [1:0] ENG_DOWN = 2'b10;

  // Door command encodings
  localparam logic [1:0] DOOR_CLOSED  = 2'b00;
  localparam logic [1:0] DOOR_OPEN    = 2'b01;
  localparam logic [1:0] DOOR_CLOSING = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StMoveUp,
    StMoveDown,
    StDoorOpen,
    StDoorClose
  } state_e;

endpackage

// File: rtl/elevator_req_scan.sv
// Combinational scan of the pending-request vector relative to a floor.
module elevator_req_scan
  import elevator_pkg::*;
#(
  parameter int unsigned BUTTONS_WIDTH = 8,
  parameter int unsigned LW            = $clog2(BUTTONS_WIDTH)
) (
  input  logic [BUTTONS_WIDTH-1:0] req,
  input  logic [LW-1:0]            level,
  output logic                     req_here,
  output logic                     req_above,
  output logic                     req_below
);

  // Classify every pending floor as at, above or below the given level
  always_comb begin
    req_here  = 1'b0;
    req_above = 1'b0;
    req_below = 1'b0;
    for (int unsigned i = 0; i < BUTTONS_WIDTH; i++) begin
      if (req[i]) begin
        if (i == 32'(level)) begin
          req_here = 1'b1;
        end else if (i > 32'(level)) begin
          req_above = 1'b1;
        end else begin
          req_below = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/elevator.sv
// Single-car elevator controller: sticky call latches, SCAN scheduling,
// registered motor/door commands and floor indicator.
module elevator
  import elevator_pkg::*;
#(
  parameter int unsigned BUTTONS_WIDTH = 8,
  parameter int unsigned FLOOR_CYCLES  = 1,
  parameter int unsigned DOOR_CYCLES   = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             open_btn,
  input  logic                             close_btn,
  input  logic [BUTTONS_WIDTH-1:0]         btn_in,
  input  logic [BUTTONS_WIDTH-1:0]         btn_up_out,
  input  logic [BUTTONS_WIDTH-1:0]         btn_down_out,
  output logic [1:0]                       engine,
  output logic [1:0]                       door,
  output logic [$clog2(BUTTONS_WIDTH)-1:0] level_display
);

  localparam int unsigned LW  = $clog2(BUTTONS_WIDTH);
  localparam int unsigned MCW = $clog2(FLOOR_CYCLES + 1);
  localparam int unsigned DCW = $clog2(DOOR_CYCLES + 1);
  localparam logic [LW-1:0]  TOP_FLOOR = LW'(BUTTONS_WIDTH - 1);
  localparam logic [MCW-1:0] MOVE_LAST = MCW'(FLOOR_CYCLES - 1);
  localparam logic [DCW-1:0] DOOR_LAST = DCW'(DOOR_CYCLES - 1);

  state_e             state_q, state_d;
  logic [LW-1:0]      level_q, level_d, level_nxt;
  logic [MCW-1:0]     move_cnt_q, move_cnt_d;
  logic [DCW-1:0]     door_cnt_q, door_cnt_d;
  logic               dir_up_q, dir_up_d;
  logic [1:0]         engine_q, engine_d, door_q, door_d;
  logic [BUTTONS_WIDTH-1:0] cab_q, up_q, down_q, req, clr, hall;
  logic here, above, below, here_nxt, above_nxt, below_nxt, arrive_stop;

  assign req = cab_q | up_q | down_q;

  elevator_req_scan #(.BUTTONS_WIDTH(BUTTONS_WIDTH), .LW(LW)) u_scan_cur (
    .req       (req),
    .level     (level_q),
    .req_here  (here),
    .req_above (above),
    .req_below (below)
  );

  // Same scan, seen from the floor the car is about to arrive at
  elevator_req_scan #(.BUTTONS_WIDTH(BUTTONS_WIDTH), .LW(LW)) u_scan_nxt (
    .req       (req),
    .level     (level_nxt),
    .req_here  (here_nxt),
    .req_above (above_nxt),
    .req_below (below_nxt)
  );

  // Next floor in the travel direction, held at the end floors
  always_comb begin
    level_nxt = level_q;
    if (state_q == StMoveUp && level_q != TOP_FLOOR) begin
      level_nxt = level_q + LW'(1);
    end else if (state_q == StMoveDown && level_q != '0) begin
      level_nxt = level_q - LW'(1);
    end
  end

  // Arrival stop: cab call, same-direction hall call, or nothing further ahead
  always_comb begin
    hall        = (state_q == StMoveUp) ? up_q : down_q;
    arrive_stop = (here_nxt && (cab_q[level_nxt] || hall[level_nxt])) ||
                  ((state_q == StMoveUp) ? !above_nxt : !below_nxt);
  end

  // FSM next state, travel and door timers
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    move_cnt_d = move_cnt_q;
    door_cnt_d = door_cnt_q;
    dir_up_d   = dir_up_q;
    unique case (state_q)
      StIdle: begin
        if (here || open_btn) begin
          state_d    = StDoorOpen;
          door_cnt_d = '0;
        end else if (above && (dir_up_q || !below)) begin
          state_d    = StMoveUp;
          dir_up_d   = 1'b1;
          move_cnt_d = '0;
        end else if (below) begin
          state_d    = StMoveDown;
          dir_up_d   = 1'b0;
          move_cnt_d = '0;
        end
      end
      StMoveUp, StMoveDown: begin
        if (move_cnt_q == MOVE_LAST) begin
          move_cnt_d = '0;
          level_d    = level_nxt;
          if (arrive_stop) begin
            state_d    = StDoorOpen;
            door_cnt_d = '0;
          end
        end else begin
          move_cnt_d = move_cnt_q + MCW'(1);
        end
      end
      StDoorOpen: begin
        // open_btn dominates close_btn
        if (open_btn) begin
          door_cnt_d = '0;
        end else if (close_btn || door_cnt_q == DOOR_LAST) begin
          state_d = StDoorClose;
        end else begin
          door_cnt_d = door_cnt_q + DCW'(1);
        end
      end
      StDoorClose: state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // Clear mask for the floor whose door is opening; new presses override it
  always_comb begin
    clr = '0;
    if (state_d == StDoorOpen && state_q != StDoorOpen) begin
      clr[level_d] = 1'b1;
    end
  end

  // Output encodings derived from the next state so the outputs are registered
  always_comb begin
    engine_d = ENG_STOP;
    door_d   = DOOR_CLOSED;
    unique case (state_d)
      StMoveUp:    engine_d = ENG_UP;
      StMoveDown:  engine_d = ENG_DOWN;
      StDoorOpen:  door_d   = DOOR_OPEN;
      StDoorClose: door_d   = DOOR_CLOSING;
      default:     ;
    endcase
  end

  // State, timers, call latches and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      level_q    <= '0;
      move_cnt_q <= '0;
      door_cnt_q <= '0;
      dir_up_q   <= 1'b1;
      cab_q      <= '0;
      up_q       <= '0;
      down_q     <= '0;
      engine_q   <= ENG_STOP;
      door_q     <= DOOR_CLOSED;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      move_cnt_q <= move_cnt_d;
      door_cnt_q <= door_cnt_d;
      dir_up_q   <= dir_up_d;
      cab_q      <= (cab_q & ~clr) | btn_in;
      up_q       <= (up_q & ~clr) | btn_up_out;
      down_q     <= (down_q & ~clr) | btn_down_out;
      engine_q   <= engine_d;
      door_q     <= door_d;
    end
  end

  assign engine        = engine_q;
  assign door          = door_q;
  assign level_display = level_q;

endmodule

// File: tb/tb_elevator.sv
// Bench for the elevator: directed vector table, hand-written corner
// sequences and randomized traffic, all checked against a floor-level model.
module tb_elevator;

  localparam int NF = 8;
  localparam int FC = 1;
  localparam int DC = 2;

  localparam int M_IDLE  = 0;
  localparam int M_UP    = 1;
  localparam int M_DOWN  = 2;
  localparam int M_OPEN  = 3;
  localparam int M_CLOSE = 4;

  logic       clk;
  logic       reset;
  logic       open_btn, close_btn;
  logic [7:0] btn_in, btn_up, btn_dn;
  logic [1:0] engine, door;
  logic [2:0] level_display;

  int total = 0;
  int bad   = 0;

  // Model of the car: floor, activity, timers, and the three call sets
  int m_floor, m_mode, m_mcnt, m_dcnt;
  bit m_dir_up;
  bit m_cab[NF];
  bit m_up[NF];
  bit m_dn[NF];

  typedef struct {
    logic [7:0] bi, bu, bd;
    logic       op, cl;
    logic [1:0] eng, dr;
    logic [2:0] lvl;
  } vec_t;
  vec_t vecs[$];

  elevator #(.BUTTONS_WIDTH(NF), .FLOOR_CYCLES(FC), .DOOR_CYCLES(DC)) dut (
    .clk           (clk),
    .reset         (reset),
    .open_btn      (open_btn),
    .close_btn     (close_btn),
    .btn_in        (btn_in),
    .btn_up_out    (btn_up),
    .btn_down_out  (btn_dn),
    .engine        (engine),
    .door          (door),
    .level_display (level_display)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit any_req(int f);
    return m_cab[f] || m_up[f] || m_dn[f];
  endfunction

  function automatic bit any_between(int lo, int hi);
    for (int f = lo; f <= hi; f++) if (f >= 0 && f < NF && any_req(f)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    m_floor = 0; m_mode = M_IDLE; m_mcnt = 0; m_dcnt = 0; m_dir_up = 1'b1;
    for (int f = 0; f < NF; f++) begin
      m_cab[f] = 1'b0; m_up[f] = 1'b0; m_dn[f] = 1'b0;
    end
  endfunction

  // One clock edge of the car, using the inputs present at that edge
  function automatic void model_step();
    int nm, nf;
    bit entry, ab, be, stop;
    nm = m_mode; nf = m_floor; entry = 1'b0;
    case (m_mode)
      M_IDLE: begin
        ab = any_between(m_floor + 1, NF - 1);
        be = any_between(0, m_floor - 1);
        if (any_req(m_floor) || open_btn) begin
          nm = M_OPEN; entry = 1'b1;
        end else if (ab && (m_dir_up || !be)) begin
          nm = M_UP; m_dir_up = 1'b1; m_mcnt = 0;
        end else if (be) begin
          nm = M_DOWN; m_dir_up = 1'b0; m_mcnt = 0;
        end
      end
      M_UP, M_DOWN: begin
        if (m_mcnt == FC - 1) begin
          m_mcnt = 0;
          nf = (m_mode == M_UP) ? m_floor + 1 : m_floor - 1;
          if (nf < 0) nf = 0;
          if (nf > NF - 1) nf = NF - 1;
          if (m_mode == M_UP) stop = m_cab[nf] || m_up[nf] || !any_between(nf + 1, NF - 1);
          else                stop = m_cab[nf] || m_dn[nf] || !any_between(0, nf - 1);
          if (stop) begin
            nm = M_OPEN; entry = 1'b1;
          end
        end else begin
          m_mcnt++;
        end
      end
      M_OPEN: begin
        if (open_btn) m_dcnt = 0;
        else if (close_btn || m_dcnt == DC - 1) nm = M_CLOSE;
        else m_dcnt++;
      end
      default: nm = M_IDLE;
    endcase
    if (entry) begin
      m_cab[nf] = 1'b0; m_up[nf] = 1'b0; m_dn[nf] = 1'b0; m_dcnt = 0;
    end
    for (int f = 0; f < NF; f++) begin
      if (btn_in[f]) m_cab[f] = 1'b1;
      if (btn_up[f]) m_up[f]  = 1'b1;
      if (btn_dn[f]) m_dn[f]  = 1'b1;
    end
    m_mode  = nm;
    m_floor = nf;
  endfunction

  function automatic int exp_eng();
    return (m_mode == M_UP) ? 1 : (m_mode == M_DOWN) ? 2 : 0;
  endfunction

  function automatic int exp_door();
    return (m_mode == M_OPEN) ? 1 : (m_mode == M_CLOSE) ? 2 : 0;
  endfunction

  // Advance one edge, then compare all outputs with the model
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("engine", int'(engine), exp_eng());
    chk("door", int'(door), exp_door());
    chk("level", int'(level_display), m_floor);
  endtask

  task automatic clear_inputs();
    btn_in = '0; btn_up = '0; btn_dn = '0; open_btn = 1'b0; close_btn = 1'b0;
  endtask

  task automatic press(input logic [7:0] bi, input logic [7:0] bu, input logic [7:0] bd);
    btn_in = bi; btn_up = bu; btn_dn = bd;
    tick();
    clear_inputs();
  endtask

  task automatic wait_door(input int val, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (int'(door) == val) seen = 1'b1;
    end
    chk(name, int'(seen), 1);
  endtask

  task automatic add(input logic [7:0] bi, input logic [7:0] bu, input logic [7:0] bd,
                     input logic [1:0] eng, input logic [1:0] dr, input logic [2:0] lvl);
    vec_t v;
    v.bi = bi; v.bu = bu; v.bd = bd; v.op = 1'b0; v.cl = 1'b0;
    v.eng = eng; v.dr = dr; v.lvl = lvl;
    vecs.push_back(v);
  endtask

  initial begin
    bit seen;
    clear_inputs();
    reset = 1'b0;
    model_reset();
    #12;
    chk("reset_level", int'(level_display), 0);
    chk("reset_engine", int'(engine), 0);
    chk("reset_door", int'(door), 0);
    reset = 1'b1;
    tick();
    tick();
    chk("reset_no_req", int'(engine), 0);

    // Floor 0 -> 7 cab call, hall down at 7 (no motion), hall down at 0
    add(8'h80, 8'h00, 8'h00, 2'd0, 2'd0, 3'd0);
    for (int l = 0; l <= 6; l++) add(8'h00, 8'h00, 8'h00, 2'd1, 2'd0, 3'(l));
    add(8'h00, 8'h00, 8'h00, 2'd0, 2'd1, 3'd7);
    add(8'h00, 8'h00, 8'h00, 2'd0, 2'd1, 3'd7);
    add(8'h00, 8'h00, 8'h00, 2'd0, 2'd2, 3'd7);
    add(8'h00, 8'h00, 8'h00, 2'd0, 2'd0, 3'd7);
    add(8'h00, 8'h00, 8'h80, 2'd0, 2'd0, 3'd7);
    add(8'h00, 8'h00, 8'h00, 2'd0, 2'd1, 3'd7);
    add(8'h00, 8'h00, 8'h00, 2'd0, 2'd1, 3'd7);
    add(8'h00, 8'h00, 8'h00, 2'd0, 2'd2, 3'd7);
    add(8'h00, 8'h00, 8'h00, 2'd0, 2'd0, 3'd7);
    add(8'h00, 8'h00, 8'h01, 2'd0, 2'd0, 3'd7);
    for (int l = 7; l >= 1; l--) add(8'h00, 8'h00, 8'h00, 2'd2, 2'd0, 3'(l));
    add(8'h00, 8'h00, 8'h00, 2'd0, 2'd1, 3'd0);
    add(8'h00, 8'h00, 8'h00, 2'd0, 2'd1, 3'd0);
    add(8'h00, 8'h00, 8'h00, 2'd0, 2'd2, 3'd0);
    add(8'h00, 8'h00, 8'h00, 2'd0, 2'd0, 3'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      btn_in = vecs[i].bi; btn_up = vecs[i].bu; btn_dn = vecs[i].bd;
      open_btn = vecs[i].op; close_btn = vecs[i].cl;
      tick();
      chk($sformatf("vec%0d_engine", i), int'(engine), int'(vecs[i].eng));
      chk($sformatf("vec%0d_door", i), int'(door), int'(vecs[i].dr));
      chk($sformatf("vec%0d_level", i), int'(level_display), int'(vecs[i].lvl));
    end
    clear_inputs();

    // Up-run from 0 to 7 stops at 3 for a hall up call, then continues
    press(8'h80, 8'h08, 8'h00);
    wait_door(1, "upcall_open1");
    chk("upcall_stop3", int'(level_display), 3);
    wait_door(0, "upcall_close1");
    wait_door(1, "upcall_open2");
    chk("upcall_stop7", int'(level_display), 7);
    wait_door(0, "upcall_close2");

    // Back to 0, then a hall down call at 3 must not stop the up-run
    press(8'h01, 8'h00, 8'h00);
    wait_door(1, "home_open");
    chk("home_level", int'(level_display), 0);
    wait_door(0, "home_close");
    press(8'h80, 8'h00, 8'h08);
    wait_door(1, "downcall_open1");
    chk("downcall_pass3", int'(level_display), 7);
    wait_door(0, "downcall_close1");
    wait_door(1, "downcall_open2");
    chk("downcall_serve3", int'(level_display), 3);
    wait_door(0, "downcall_close2");

    // open_btn held keeps the door open; close_btn ends it at the next edge
    open_btn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("open_hold", int'(door), 1);
    end
    open_btn = 1'b0;
    close_btn = 1'b1;
    tick();
    chk("close_btn", int'(door), 2);
    close_btn = 1'b0;
    tick();
    chk("close_done", int'(door), 0);

    // Reset while travelling up past floor 4
    press(8'h80, 8'h00, 8'h00);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (int'(level_display) == 4 && int'(engine) == 1) seen = 1'b1;
      else tick();
    end
    chk("reach_floor4", int'(seen), 1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("midreset_level", int'(level_display), 0);
    chk("midreset_engine", int'(engine), 0);
    chk("midreset_door", int'(door), 0);
    #2;
    reset = 1'b1;
    tick();
    tick();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      btn_in    = ($urandom_range(0, 7) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      btn_up    = ($urandom_range(0, 9) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      btn_dn    = ($urandom_range(0, 9) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      open_btn  = ($urandom_range(0, 15) == 0);
      close_btn = ($urandom_range(0, 9) == 0);
      tick();
    end
    clear_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/elevator.md
# elevator

Controller for a single car serving BUTTONS_WIDTH floors, numbered 0 to BUTTONS_WIDTH-1. It latches cab and hall calls, schedules travel with a collective (SCAN) policy, and drives the motor command, the door command and the floor indicator. It sits between the button/sensor front-end and the motor/door actuators, and all floor timing is internal.

## Interface
- BUTTONS_WIDTH, 8: number of floors; one request bit per floor.
- FLOOR_CYCLES, 1: clock cycles to travel one floor.
- DOOR_CYCLES, 2: clock cycles the door stays open.
- clk  in  1  system clock; everything is rising-edge.
- reset  in  1  **one clock; reset is asynchronous and active-low.**
- open_btn  in  1  cab door-open button, level-sampled.
- close_btn  in  1  cab door-close button, level-sampled.
- btn_in  in  BUTTONS_WIDTH  cab floor buttons, bit i = floor i.
- btn_up_out  in  BUTTONS_WIDTH  hall up calls.
- btn_down_out  in  BUTTONS_WIDTH  hall down calls.
- engine  out  2  motor command: 00 stop, 01 up, 10 down; 11 never driven.
- door  out  2  door command: 00 closed, 01 open, 10 closing; 11 never driven.
- level_display  out  $clog2(BUTTONS_WIDTH)  current floor, binary.

## Operation
- Request register: req = OR of the three button vectors, sticky.
  - A bit is set on any rising edge where its button is high.
  - A bit is cleared when the door opens at that floor.
  - A bit set in the same cycle as its clear stays set.
- FSM states:
  - IDLE: engine 00, door 00.
  - MOVE_UP: engine 01.
  - MOVE_DOWN: engine 10.
  - DOOR_OPEN: door 01.
  - DOOR_CLOSE: door 10, lasts 1 cycle.
- IDLE transitions:
  - req at the current floor, or open_btn: go to DOOR_OPEN.
  - else a req above: go to MOVE_UP.
  - else a req below: go to MOVE_DOWN.
  - else stay in IDLE.
  - Requests above beat requests below only when dir_up, the last travel direction, is 1. Otherwise below wins.
- MOVE_*: each FLOOR_CYCLES cycles, level steps by ±1. On arrival, stop (go to DOOR_OPEN) if any of these holds:
  - btn_in req at that floor;
  - hall call at that floor matching the travel direction;
  - no req further in the travel direction.
- Otherwise the car keeps moving. Direction never reverses while a req is pending ahead.
- DOOR_OPEN:
  - Lasts DOOR_CYCLES cycles.
  - open_btn reloads the timer.
  - close_btn ends the open period at the next edge; open_btn wins if both are high.
  - Then go to DOOR_CLOSE, then IDLE.
  - All req bits of the current floor clear on entry.
- open_btn and close_btn are ignored while moving.
- level_display is clamped to 0..BUTTONS_WIDTH-1. The car never moves past the end floors.

## Timing
- Reset (async assert, sync release) sets:
  - level_display 0;
  - engine 00;
  - door 00;
  - state IDLE;
  - req 0;
  - dir_up 1;
  - timers 0.
- Reset mid-travel abandons the trip immediately; the car resumes at floor 0.
- All outputs are registered. A button high at edge N:
  - sets req at edge N;
  - FSM leaves IDLE at edge N+1.
- The car reaches floor k from floor j after |k-j|·FLOOR_CYCLES cycles of nonzero engine.
- Door sequence: DOOR_OPEN for DOOR_CYCLES cycles, then DOOR_CLOSE for 1 cycle, then IDLE.
- A call at the current floor during DOOR_CLOSE reopens the door on the next cycle, via IDLE.

## Structure
- Shared package `elevator_pkg` holds:
  - the engine encodings ENG_STOP/ENG_UP/ENG_DOWN;
  - the door encodings DOOR_CLOSED/DOOR_OPEN/DOOR_CLOSING;
  - the FSM state enum.
- One sub-module, `elevator_req_scan`, is combinational. It takes req and level and outputs:
  - req_here;
  - req_above;
  - req_below.
- The FSM, timers and request register live in `elevator`.

## Test plan
- Reset low then high: level_display 0, engine 00, door 00, req empty.
- From floor 0, btn_in[7] high for one edge:
  - engine 01 for 7 cycles;
  - level_display counts 1…7;
  - door 01 for 2 cycles, then 10 for 1 cycle, then 00;
  - car stays at 7.
- At floor 7 idle, btn_down_out[7] pulse: door opens with no motion (engine stays 00).
- At floor 7, btn_down_out[0] pulse:
  - engine 10 for 7 cycles;
  - stop at floor 0, door cycle.
- Going up from 0 to 7 with btn_up_out[3] pulsed before the car passes 3: car stops at 3, door cycle, then continues to 7. btn_down_out[3] alone does not stop the up-run.
- Door behaviour: open_btn held during DOOR_OPEN keeps door 01. close_btn closes the door after 1 cycle. Reset asserted while engine 01 at floor 4 gives level 0 and engine 00 at once.
